uart_rx_fifo: RTL and testbench

Board-side UART receiver that deserializes 8N1 frames from the SoC's `uart_tx` line and buffers the received bytes in a small FIFO with a valid/ready output. It is the receiving end of the SoC UART link and sits in the board top level. Typical consumers are loopback checks, a console sniffer, or a command decoder on the FPGA fabric. Errors are reported as sticky flags, cleared by the consumer.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync_fifo.sv | 48 ++++
 rtl/uart_rx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: state encoding, frame width and the
// bit-period helper used to size the receive timer.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_e;

    function automatic int uart_cycles_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock byte FIFO with extra-MSB pointers; a pop frees the slot a
// simultaneous push into a full FIFO needs, so both are accepted together.
module uart_rx_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with sticky error flags feeding a byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames; otherwise 8N1 and parity_error is 0.
//
// state        | meaning
// IDLE         | line high, waiting for a start edge
// START        | timing to start-bit middle, rejects glitches
// DATA         | sampling 8 data bits LSB first
// PARITY       | sampling the even-parity bit (parity builds only)
// STOP         | sampling the stop bit, push or flag framing error
// WAIT_IDLE    | after a framing error, waiting for the line to return high
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [UART_DATA_BITS-1:0]     rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_error,
    output logic                          overrun_error,
    output logic                          parity_error,
    input  logic                          error_clear
);

    localparam int CPB = uart_cycles_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int TW  = $clog2(CPB + 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CPB / 2 - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      sync1_q, sync2_q;
    uart_rx_state_e            state_q, state_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_error_q, overrun_error_q;
    logic                      tc;
    logic                      push;
    logic                      frame_set;
    logic                      overrun_set;
    logic                      fifo_empty;
    logic                      fifo_full;
`ifdef UART_RX_PARITY_EN
    logic                      parity_set;
    logic                      parity_error_q;
`endif

    assign tc = (timer_q == '0);

    always_comb begin
        state_d   = state_q;
        timer_d   = tc ? FULL_LOAD : timer_q - TW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                timer_d = HALF_LOAD;
                if (!sync2_q) state_d = ST_START;
            end
            ST_START: begin
                if (tc) begin
                    bit_idx_d = '0;
                    state_d   = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tc) begin
                    shift_d   = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == LAST_BIT) state_d = ST_PARITY;
`else
                    if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tc) begin
                    parity_set = (sync2_q != ^shift_q);
                    state_d    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tc) begin
                    if (sync2_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (sync2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop in the push cycle makes room, so only an unserved full FIFO overruns.
    assign overrun_set = push && fifo_full && !rx_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            frame_error_q   <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            sync1_q         <= uart_rx;
            sync2_q         <= sync1_q;
            state_q         <= state_d;
            timer_q         <= timer_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            frame_error_q   <= frame_set   | (frame_error_q   & ~error_clear);
            overrun_error_q <= overrun_set | (overrun_error_q & ~error_clear);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) parity_error_q <= 1'b0;
        else        parity_error_q <= parity_set | (parity_error_q & ~error_clear);
    end
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

    assign frame_error   = frame_error_q;
    assign overrun_error = overrun_error_q;
    assign rx_valid      = !fifo_empty;

    uart_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i       (clock),
        .rst_n_i     (reset),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (rx_ready),
        .head_o      (rx_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (rx_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 12 cycles per bit with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 1000000;
    localparam int DEPTH  = 4;
    localparam int CPB    = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       error_clear = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_error;
    logic       overrun_error;
    logic       parity_error;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_fifo #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .UART_BAUD_RATE  (BAUD),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .frame_error   (frame_error),
        .overrun_error (overrun_error),
        .parity_error  (parity_error),
        .error_clear   (error_clear)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // ready_pulse raises rx_ready for exactly the stop-sample cycle (9th stop cycle).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit ready_pulse);
        uart_rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            step(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^d) ^ par_flip;
        step(CPB);
`endif
        uart_rx = stop_bit;
        if (ready_pulse) begin
            step(8);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
            step(3);
        end else begin
            step(CPB);
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_drain(input int n);
        int k = 0;
        while (exp_q.size() != 0 && k < n) begin
            step(1);
            k++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: remaining=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_clear();
        error_clear = 1'b1;
        step(1);
        error_clear = 1'b0;
        step(1);
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (reset && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", 32'(rx_data), 32'(e));
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        step(3);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_count", 32'(rx_count), 0);
        check("rst_frame", 32'(frame_error), 0);
        check("rst_overrun", 32'(overrun_error), 0);
        check("rst_parity", 32'(parity_error), 0);
        reset = 1'b1;
        step(5);

        // single frame with consumer ready
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        step(4);
        wait_drain(50);
        check("a5_count", 32'(rx_count), 0);
        check("a5_valid", 32'(rx_valid), 0);
        check("a5_frame", 32'(frame_error), 0);
        check("a5_overrun", 32'(overrun_error), 0);

        // 3-cycle glitch on idle line
        uart_rx = 1'b0;
        step(3);
        uart_rx = 1'b1;
        step(30);
        check("glitch_valid", 32'(rx_valid), 0);
        check("glitch_frame", 32'(frame_error), 0);
        check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));

        // framing error, break, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        uart_rx = 1'b0;
        step(40);
        uart_rx = 1'b1;
        step(CPB);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        step(4);
        wait_drain(50);
        check("ferr_set", 32'(frame_error), 1);
        check("ferr_overrun", 32'(overrun_error), 0);
        pulse_clear();
        check("ferr_clear", 32'(frame_error), 0);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        step(2);
        check("ovr_count", 32'(rx_count), 4);
        check("ovr_flag", 32'(overrun_error), 1);
        check("ovr_head", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        wait_drain(20);
        check("ovr_drained", 32'(rx_count), 0);
        check("ovr_sticky", 32'(overrun_error), 1);
        pulse_clear();
        check("ovr_clear", 32'(overrun_error), 0);

        // push and pop together while full
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
        end
        check("full_count", 32'(rx_count), 4);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b1);
        check("pp_count", 32'(rx_count), 4);
        check("pp_overrun", 32'(overrun_error), 0);
        rx_ready = 1'b1;
        wait_drain(20);
        check("pp_drained", 32'(rx_count), 0);

        // reset mid-frame, then recover
        rx_ready = 1'b0;
        send_frame(8'h66, 1'b1, 1'b0);
        step(2);
        check("pre_rst_valid", 32'(rx_valid), 1);
        uart_rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i % 2 == 0);
            step(CPB);
        end
        uart_rx = 1'b0;
        step(6);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_data", 32'(rx_data), 0);
        check("mid_rst_count", 32'(rx_count), 0);
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        uart_rx = 1'b1;
        step(3);
        reset = 1'b1;
        step(5);
        rx_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        step(4);
        wait_drain(50);
        check("post_rst_count", 32'(rx_count), 0);
        check("post_rst_frame", 32'(frame_error), 0);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        par_flip = 1'b0;
        step(4);
        wait_drain(50);
        check("parity_set", 32'(parity_error), 1);
`else
        check("parity_tied", 32'(parity_error), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
